// File: rtl/arc4_seq.sv
// arc4_seq - ARC4 top-level sequencer.
// Runs the init, ksa and prga passes in order over their en/rdy handshakes.
// It owns the single-port S memory write/address port and latches the key at start.
// Optional per-stage watchdog: define ARC4_SEQ_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module arc4_seq #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [23:0] key_q,
    output logic        err,
    output logic [1:0]  owner,
    output logic        init_en,
    input  logic        init_rdy,
    output logic        ksa_en,
    input  logic        ksa_rdy,
    output logic        prga_en,
    input  logic        prga_rdy,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_wrdata,
    input  logic        init_wren,
    input  logic [7:0]  ksa_addr,
    input  logic [7:0]  ksa_wrdata,
    input  logic        ksa_wren,
    input  logic [7:0]  prga_addr,
    input  logic [7:0]  prga_wrdata,
    input  logic        prga_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);
    // state       | meaning
    // ST_IDLE     | waiting for en, rdy=1, no S grant
    // ST_S_INIT   | init_en follows init_rdy; leave once init accepts
    // ST_B_INIT   | init running; first cycle ignores init_rdy
    // ST_S_KSA    | ksa_en follows ksa_rdy; leave once ksa accepts
    // ST_B_KSA    | ksa running; first cycle ignores ksa_rdy
    // ST_S_PRGA   | prga_en follows prga_rdy; leave once prga accepts
    // ST_B_PRGA   | prga running; first cycle ignores prga_rdy
    typedef enum logic [2:0] {
        ST_IDLE, ST_S_INIT, ST_B_INIT, ST_S_KSA, ST_B_KSA, ST_S_PRGA, ST_B_PRGA
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INIT = 2'd1;
    localparam logic [1:0] OWN_KSA  = 2'd2;
    localparam logic [1:0] OWN_PRGA = 2'd3;

    state_t     state;
    state_t     busy_state;
    state_t     adv_state;
    logic [1:0] adv_owner;
    logic       cur_rdy;
    logic       first_q;

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("arc4_seq: TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef ARC4_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    // Per-stage view: rdy of the active sub-block, its busy state and where it exits to.
    always_comb begin
        cur_rdy    = 1'b0;
        busy_state = ST_IDLE;
        adv_state  = ST_IDLE;
        adv_owner  = OWN_NONE;
        case (state)
            ST_S_INIT, ST_B_INIT: begin
                cur_rdy    = init_rdy;
                busy_state = ST_B_INIT;
                adv_state  = ST_S_KSA;
                adv_owner  = OWN_KSA;
            end
            ST_S_KSA, ST_B_KSA: begin
                cur_rdy    = ksa_rdy;
                busy_state = ST_B_KSA;
                adv_state  = ST_S_PRGA;
                adv_owner  = OWN_PRGA;
            end
            ST_S_PRGA, ST_B_PRGA: begin
                cur_rdy    = prga_rdy;
                busy_state = ST_B_PRGA;
                adv_state  = ST_IDLE;
                adv_owner  = OWN_NONE;
            end
            default: ;
        endcase
    end

    // Sequencer FSM; owner and rdy are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rdy     <= 1'b1;
            owner   <= OWN_NONE;
            key_q   <= '0;
            first_q <= 1'b0;
`ifdef ARC4_SEQ_TIMEOUT_EN
            err     <= 1'b0;
            wd_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_S_INIT;
                        owner <= OWN_INIT;
                        rdy   <= 1'b0;
                        key_q <= key;
`ifdef ARC4_SEQ_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                    end
                end
                ST_S_INIT, ST_S_KSA, ST_S_PRGA: begin
                    if (cur_rdy) begin
                        state   <= busy_state;
                        first_q <= 1'b1;
`ifdef ARC4_SEQ_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                ST_B_INIT, ST_B_KSA, ST_B_PRGA: begin
                    // The sub-block's rdy is still high on the first busy cycle.
                    first_q <= 1'b0;
                    if (!first_q && cur_rdy) begin
                        state <= adv_state;
                        owner <= adv_owner;
                        rdy   <= (adv_state == ST_IDLE);
                    end
`ifdef ARC4_SEQ_TIMEOUT_EN
                    else if (wd_cnt + 16'd1 == WD_LIMIT) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                        rdy   <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign init_en = (state == ST_S_INIT) && init_rdy;
    assign ksa_en  = (state == ST_S_KSA)  && ksa_rdy;
    assign prga_en = (state == ST_S_PRGA) && prga_rdy;

    // S port mux: only the granted requester reaches the memory.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (owner)
            OWN_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            OWN_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            OWN_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_arc4_seq.sv
// tb_arc4_seq - bench for arc4_seq with stub sub-blocks of programmable latency.
module tb_arc4_seq;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [23:0] key_q;
    logic        err;
    logic [1:0]  owner;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
    logic        init_wren, ksa_wren, prga_wren;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;

    int total = 0;
    int bad   = 0;

    // stub sub-blocks: rdy drops on the accepting edge, rises L edges later
    logic [2:0] st_rdy;
    logic [2:0] st_stall;
    logic [2:0] sub_en;
    int         st_cnt [3];
    int         st_lat [3];

    arc4_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
        .err(err), .owner(owner),
        .init_en(init_en), .init_rdy(init_rdy),
        .ksa_en(ksa_en), .ksa_rdy(ksa_rdy),
        .prga_en(prga_en), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    always #5 clk = ~clk;

    assign sub_en   = {prga_en, ksa_en, init_en};
    assign init_rdy = st_rdy[0];
    assign ksa_rdy  = st_rdy[1];
    assign prga_rdy = st_rdy[2];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                st_rdy[i] <= 1'b1;
                st_cnt[i] <= 0;
            end else if (sub_en[i] && st_rdy[i]) begin
                st_rdy[i] <= 1'b0;
                st_cnt[i] <= st_lat[i] - 1;
            end else if (!st_rdy[i] && !st_stall[i]) begin
                if (st_cnt[i] == 0) st_rdy[i] <= 1'b1;
                else                st_cnt[i] <= st_cnt[i] - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic rand_reqs();
        init_addr   = 8'($urandom); init_wrdata = 8'($urandom); init_wren = 1'($urandom_range(0, 1));
        ksa_addr    = 8'($urandom); ksa_wrdata  = 8'($urandom); ksa_wren  = 1'($urandom_range(0, 1));
        prga_addr   = 8'($urandom); prga_wrdata = 8'($urandom); prga_wren = 1'($urandom_range(0, 1));
    endtask

    // Timeline model: n = edges since the accepting edge, stage with latency L lasts L+2 cycles.
    function automatic logic [1:0] exp_owner(int n, int li, int lk, int lp);
        if (n <= li + 1)           return 2'd1;
        if (n <= li + lk + 3)      return 2'd2;
        if (n <= li + lk + lp + 5) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [2:0] exp_en(int n, int li, int lk);
        logic [2:0] v;
        v = 3'b000;
        if (n == 0)           v[0] = 1'b1;
        if (n == li + 2)      v[1] = 1'b1;
        if (n == li + lk + 4) v[2] = 1'b1;
        return v;
    endfunction

    task automatic check_s(input logic [1:0] o);
        logic [7:0] ea, ed;
        logic       ew;
        ea = 8'd0; ed = 8'd0; ew = 1'b0;
        case (o)
            2'd1: begin ea = init_addr; ed = init_wrdata; ew = init_wren; end
            2'd2: begin ea = ksa_addr;  ed = ksa_wrdata;  ew = ksa_wren;  end
            2'd3: begin ea = prga_addr; ed = prga_wrdata; ew = prga_wren; end
            default: ;
        endcase
        chk("s_addr", s_addr, ea);
        chk("s_wrdata", s_wrdata, ed);
        chk("s_wren", s_wren, ew);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy"}, rdy, 1);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_key_q"}, key_q, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_x_en"}, {prga_en, ksa_en, init_en}, 0);
        chk({tag, "_s_addr"}, s_addr, 0);
        chk({tag, "_s_wrdata"}, s_wrdata, 0);
        chk({tag, "_s_wren"}, s_wren, 0);
    endtask

    // Full run with per-cycle checks; noise toggles en/key while busy.
    task automatic run_seq(input logic [23:0] kv, input int li, input int lk, input int lp,
                           input int tot, input bit noise);
        int ni, nk, np;
        ni = 0; nk = 0; np = 0;
        @(negedge clk);
        st_lat[0] = li; st_lat[1] = lk; st_lat[2] = lp;
        key = kv; en = 1'b1; rand_reqs();
        #1;
        chk("pre_rdy", rdy, 1);
        for (int n = 0; n <= tot; n++) begin
            @(negedge clk);
            if (noise && n < tot) begin
                en  = 1'($urandom_range(0, 1));
                key = 24'($urandom);
            end else begin
                en = 1'b0;
            end
            rand_reqs();
            #1;
            chk("owner", owner, exp_owner(n, li, lk, lp));
            chk("rdy", rdy, 32'(n == tot));
            chk("key_q", key_q, kv);
            chk("err", err, 0);
            chk("x_en", {prga_en, ksa_en, init_en}, exp_en(n, li, lk));
            check_s(exp_owner(n, li, lk, lp));
            ni += int'(init_en); nk += int'(ksa_en); np += int'(prga_en);
        end
        chk("init_pulses", ni, 1);
        chk("ksa_pulses", nk, 1);
        chk("prga_pulses", np, 1);
    endtask

    // Leaves the bench at the negedge of cycle k=0 (first cycle after acceptance).
    task automatic start_run(input logic [23:0] kv, input int li, input int lk, input int lp);
        @(negedge clk);
        st_lat[0] = li; st_lat[1] = lk; st_lat[2] = lp;
        key = kv; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        chk("wait_idle", ok, 1);
    endtask

    typedef struct {
        logic [23:0] kv;
        int          li, lk, lp;
        int          tot;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int pen;
        vecs[0] = '{24'h000318, 3, 5, 7, 21};
        vecs[1] = '{24'hA5A5A5, 1, 1, 1, 9};
        vecs[2] = '{24'hFFFFFF, 8, 2, 4, 20};
        vecs[3] = '{24'h123ABC, 6, 6, 6, 24};
        vecs[4] = '{24'h000001, 1, 8, 2, 17};

        rst_n = 1'b0; en = 1'b1; key = 24'hABCDEF; st_stall = 3'b000;
        st_lat[0] = 1; st_lat[1] = 1; st_lat[2] = 1;
        rand_reqs();
        init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;

        // reset
        @(negedge clk);
        #1;
        check_reset_vals("reset");
        en = 1'b0;
        rst_n = 1'b1;

        // table-driven full runs, first one quiet, rest with busy en/key noise
        for (int v = 0; v < 5; v++)
            run_seq(vecs[v].kv, vecs[v].li, vecs[v].lk, vecs[v].lp, vecs[v].tot, v != 0);

        // randomized latencies and keys
        for (int r = 0; r < 6; r++) begin
            int li, lk, lp;
            li = $urandom_range(1, 8); lk = $urandom_range(1, 8); lp = $urandom_range(1, 8);
            run_seq(24'($urandom), li, lk, lp, li + lk + lp + 6, 1'b1);
        end

        // grant isolation during B_INIT
        start_run(24'h0A0B0C, 3, 2, 2);
        @(negedge clk);
        @(negedge clk);
        init_addr = 8'h05; init_wrdata = 8'h05; init_wren = 1'b1;
        ksa_addr = 8'hAA; ksa_wrdata = 8'h11; ksa_wren = 1'b1;
        prga_addr = 8'h33; prga_wrdata = 8'h44; prga_wren = 1'b1;
        #1;
        chk("iso_s_addr", s_addr, 8'h05);
        chk("iso_s_wrdata", s_wrdata, 8'h05);
        chk("iso_s_wren", s_wren, 1);
        chk("iso_owner", owner, 1);
        @(negedge clk);
        init_wren = 1'b0;
        #1;
        chk("iso_nonowner_wren", s_wren, 0);
        wait_idle(100);

        // en with a new key while busy in B_KSA
        start_run(24'h123456, 1, 6, 1);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            en  = (k >= 5 && k <= 7);
            key = 24'hFFFFFF;
            #1;
            if (k >= 5) begin
                chk("busy_owner", owner, 2);
                chk("busy_ksa_en", ksa_en, 0);
                chk("busy_init_en", init_en, 0);
                chk("busy_key_q", key_q, 24'h123456);
                chk("busy_rdy", rdy, 0);
            end
        end
        en = 1'b0;
        wait_idle(100);
        chk("busy_key_q_end", key_q, 24'h123456);

        // reset during B_PRGA, then a fresh run
        start_run(24'h55AA55, 2, 2, 6);
        repeat (10) @(negedge clk);
        init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
        #1;
        chk("mid_owner_prga", owner, 3);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_vals("midrst");
        rst_n = 1'b1;
        run_seq(24'h00C0DE, 2, 2, 2, 12, 1'b0);

        // ksa never returns rdy
        st_stall = 3'b010;
        pen = 0;
        start_run(24'h777777, 2, 3, 2);
`ifdef ARC4_SEQ_TIMEOUT_EN
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            pen += int'(prga_en);
            if (k == 20) begin
                chk("to_owner_before", owner, 2);
                chk("to_rdy_before", rdy, 0);
                chk("to_err_before", err, 0);
            end
            if (k == 21) begin
                chk("to_err", err, 1);
                chk("to_rdy", rdy, 1);
                chk("to_owner", owner, 0);
            end
        end
        chk("to_prga_en", pen, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("to_err_hold", err, 1);
        st_stall = 3'b000;
        repeat (10) @(negedge clk);
`else
        for (int k = 0; k <= 45; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            pen += int'(prga_en);
            if (k >= 5) begin
                chk("stall_owner", owner, 2);
                chk("stall_rdy", rdy, 0);
                chk("stall_err", err, 0);
            end
        end
        chk("stall_prga_en", pen, 0);
        st_stall = 3'b000;
        wait_idle(100);
`endif
        run_seq(24'hBEEF01, 4, 4, 4, 18, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
